sudoku_solve_ctrl: RTL and testbench

//  Sequencer for the combinational/iterative sudoku solver datapath.
//  - Accepts a puzzle on a start handshake, validates it, loads it into the solver via the solver's load/reset pin.
//  - Monitors the solver's board every cycle.
//  - Terminates the run as solved, stalled (fixpoint), timed-out or bad-input, then presents the latched result.
//  - Sits between the user/IO front end and the solver core.

---
 rtl/sudoku_pkg.sv | 27 ++
 rtl/sudoku_board_stats.sv | 26 ++
 rtl/sudoku_solve_ctrl.sv | 152 +++++++++++++++
 tb/tb_sudoku_solve_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
// Shared constants for the sudoku solver sequencer: board geometry, status codes,
// FSM encodings and a cell accessor for the row-major BCD board packing.
package sudoku_pkg;

    localparam int GRID_SIZE = 9;
    localparam int NUM_CELLS = GRID_SIZE * GRID_SIZE;
    localparam int BOARD_W   = 4 * NUM_CELLS;

    localparam logic [2:0] STATUS_NONE      = 3'd0;
    localparam logic [2:0] STATUS_SOLVED    = 3'd1;
    localparam logic [2:0] STATUS_STALLED   = 3'd2;
    localparam logic [2:0] STATUS_TIMEOUT   = 3'd3;
    localparam logic [2:0] STATUS_BAD_INPUT = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Cell 0 (row 0, col 0) sits in the most significant nibble.
    function automatic logic [3:0] cell_at(input logic [BOARD_W-1:0] board, input int idx);
        return board[BOARD_W-1-4*idx -: 4];
    endfunction

endpackage

// File: rtl/sudoku_board_stats.sv
// Combinational statistics over one packed board: full, any digit >9, and the
// number of nonzero cells.
module sudoku_board_stats
    import sudoku_pkg::*;
(
    input  logic [BOARD_W-1:0] i_board,
    output logic               o_all_filled,
    output logic               o_any_invalid,
    output logic [6:0]         o_filled_count
);

    always_comb begin
        o_all_filled   = 1'b1;
        o_any_invalid  = 1'b0;
        o_filled_count = 7'd0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (cell_at(i_board, i) == 4'd0)
                o_all_filled = 1'b0;
            else
                o_filled_count = o_filled_count + 7'd1;
            if (cell_at(i_board, i) > 4'd9)
                o_any_invalid = 1'b1;
        end
    end

endmodule

// File: rtl/sudoku_solve_ctrl.sv
// Sequencer for the iterative sudoku solver: accept, validate, load, watch for
// solved/stalled/timeout, then present the latched result.
// Optional cycles_out port enabled by defining SUDOKU_CYCLE_COUNT_EN.
module sudoku_solve_ctrl
    import sudoku_pkg::*;
#(
    parameter int STALL_CYCLES = 4,
    parameter int MAX_CYCLES   = 1024,
    parameter int CNT_W        = 11
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic               start_in,
    input  logic [BOARD_W-1:0] board_in,
    output logic               ready_out,
    output logic               busy_out,
    output logic               solver_load_out,
    output logic [BOARD_W-1:0] solver_board_out,
    input  logic [BOARD_W-1:0] solver_result_in,
    output logic [BOARD_W-1:0] board_out,
    output logic [2:0]         status_out,
    output logic [6:0]         filled_out,
    output logic               done_out
`ifdef SUDOKU_CYCLE_COUNT_EN
    ,
    output logic [CNT_W-1:0]   cycles_out
`endif
);

    localparam int                 STALL_W    = $clog2(STALL_CYCLES) + 1;
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0]   RUN_LAST   = CNT_W'(MAX_CYCLES - 1);

    state_t             r_state, w_next_state;
    logic [BOARD_W-1:0] r_solver_board, r_snap, r_board;
    logic [2:0]         r_status;
    logic [6:0]         r_filled;
    logic [CNT_W-1:0]   r_run_cnt;
    logic [STALL_W-1:0] r_stall_cnt;

    logic       w_in_full, w_in_bad, w_res_full, w_res_bad;
    logic [6:0] w_in_cnt, w_res_cnt;
    logic       w_unused_stats;
    logic       w_accept, w_same, w_stalled, w_timeout, w_term;

    sudoku_board_stats u_in_stats (
        .i_board        (board_in),
        .o_all_filled   (w_in_full),
        .o_any_invalid  (w_in_bad),
        .o_filled_count (w_in_cnt)
    );

    sudoku_board_stats u_res_stats (
        .i_board        (solver_result_in),
        .o_all_filled   (w_res_full),
        .o_any_invalid  (w_res_bad),
        .o_filled_count (w_res_cnt)
    );

    assign w_unused_stats = w_in_full ^ w_res_bad;

    assign w_accept  = (r_state == ST_IDLE) && start_in;
    assign w_same    = (solver_result_in == r_snap);
    assign w_stalled = w_same && (r_stall_cnt == STALL_LAST);
    assign w_timeout = (r_run_cnt == RUN_LAST);
    assign w_term    = w_res_full || w_stalled || w_timeout;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state    = r_state;
        ready_out       = 1'b0;
        busy_out        = 1'b0;
        solver_load_out = 1'b0;
        done_out        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ready_out = 1'b1;
                if (start_in) w_next_state = w_in_bad ? ST_DONE : ST_LOAD;
            end
            ST_LOAD: begin
                busy_out        = 1'b1;
                solver_load_out = 1'b1;
                w_next_state    = ST_RUN;
            end
            ST_RUN: begin
                busy_out = 1'b1;
                if (w_term) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                busy_out     = 1'b1;
                done_out     = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_solver_board <= '0;
            r_snap         <= '0;
            r_board        <= '0;
            r_status       <= STATUS_NONE;
            r_filled       <= 7'd0;
            r_run_cnt      <= '0;
            r_stall_cnt    <= '0;
        end else if (w_accept) begin
            r_solver_board <= board_in;
            r_snap         <= board_in;
            r_run_cnt      <= '0;
            r_stall_cnt    <= '0;
            // Bad input skips the solver entirely and reports the rejected board.
            r_board        <= w_in_bad ? board_in : '0;
            r_status       <= w_in_bad ? STATUS_BAD_INPUT : STATUS_NONE;
            r_filled       <= w_in_bad ? w_in_cnt : 7'd0;
        end else if (r_state == ST_RUN) begin
            if (w_term) begin
                r_board  <= solver_result_in;
                r_filled <= w_res_cnt;
                if (w_res_full)     r_status <= STATUS_SOLVED;
                else if (w_stalled) r_status <= STATUS_STALLED;
                else                r_status <= STATUS_TIMEOUT;
            end else begin
                r_stall_cnt <= w_same ? r_stall_cnt + 1'b1 : '0;
                r_snap      <= solver_result_in;
                r_run_cnt   <= r_run_cnt + 1'b1;
            end
        end
    end

    assign solver_board_out = r_solver_board;
    assign board_out        = r_board;
    assign status_out       = r_status;
    assign filled_out       = r_filled;

`ifdef SUDOKU_CYCLE_COUNT_EN
    logic [CNT_W-1:0] r_cycles;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in)                       r_cycles <= '0;
        else if (w_accept)                  r_cycles <= '0;
        else if (r_state == ST_RUN && w_term) r_cycles <= r_run_cnt + 1'b1;
    end

    assign cycles_out = r_cycles;
`endif

endmodule

// File: tb/tb_sudoku_solve_ctrl.sv
// Scoreboard bench for sudoku_solve_ctrl with a behavioural solver model driving
// solver_result_in; expected results are hand-derived per scenario.
module tb_sudoku_solve_ctrl;
    import sudoku_pkg::*;

    localparam int BW = BOARD_W;

    typedef struct {
        int            acc;
        int            lat;
        logic [2:0]    st;
        logic [6:0]    filled;
        logic [BW-1:0] board;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_in = 1'b0;
    logic [BW-1:0] board_in = '0;
    logic          ready_out, busy_out, solver_load_out, done_out;
    logic [BW-1:0] solver_board_out, board_out;
    logic [BW-1:0] sb;
    logic [2:0]    status_out;
    logic [6:0]    filled_out;
`ifdef SUDOKU_CYCLE_COUNT_EN
    logic [10:0]   cycles_out;
`endif

    int checks = 0;
    int failures = 0;
    int ncyc = 0;
    int mode = 0;
    int step = 0;
    exp_t q[$];
    int   ldq[$];
    logic [BW-1:0] sol;

    sudoku_solve_ctrl #(.STALL_CYCLES(4), .MAX_CYCLES(16), .CNT_W(11)) dut (
        .clk_in           (clk),
        .reset_in         (rst),
        .start_in         (start_in),
        .board_in         (board_in),
        .ready_out        (ready_out),
        .busy_out         (busy_out),
        .solver_load_out  (solver_load_out),
        .solver_board_out (solver_board_out),
        .solver_result_in (sb),
        .board_out        (board_out),
        .status_out       (status_out),
        .filled_out       (filled_out),
        .done_out         (done_out)
`ifdef SUDOKU_CYCLE_COUNT_EN
        ,
        .cycles_out       (cycles_out)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) ncyc <= ncyc + 1;

    function automatic logic [BW-1:0] set_cell(input logic [BW-1:0] b, input int idx, input logic [3:0] v);
        logic [BW-1:0] r;
        r = b;
        r[BW-1-4*idx -: 4] = v;
        return r;
    endfunction

    function automatic logic [3:0] get_cell(input logic [BW-1:0] b, input int idx);
        return b[BW-1-4*idx -: 4];
    endfunction

    function automatic logic [BW-1:0] make_solution();
        logic [BW-1:0] b;
        b = '0;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                b = set_cell(b, r*9 + c, 4'(((r*3 + r/3 + c) % 9) + 1));
        return b;
    endfunction

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        checks++;
        failures++;
        $display("FAIL %s", nm);
    endtask

    // Behavioural solver: load on the pulse, then evolve according to mode.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sb   <= '0;
            step <= 0;
        end else if (solver_load_out) begin
            sb   <= solver_board_out;
            step <= 0;
        end else begin
            step <= step + 1;
            case (mode)
                1: if (step < 3) sb <= set_cell(sb, step, get_cell(sol, step));
                2: sb <= sb ^ BW'(1);
                3: sb <= (step == 14) ? sol : (sb ^ (BW'(1) << 4));
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (solver_load_out) begin
                if (ldq.size() == 0) flag("unexpected_load");
                else chk("load_latency", BW'(ncyc - ldq.pop_front()), BW'(1));
            end
            if (done_out) begin
                if (q.size() == 0) flag("unexpected_done");
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("done_latency", BW'(ncyc - e.acc), BW'(e.lat));
                    chk("status", BW'(status_out), BW'(e.st));
                    chk("filled", BW'(filled_out), BW'(e.filled));
                    chk("board", board_out, e.board);
                    chk("busy_in_done", BW'(busy_out), BW'(1));
`ifdef SUDOKU_CYCLE_COUNT_EN
                    chk("cycles", BW'(cycles_out), BW'(e.cyc));
`endif
                end
            end
        end
    end

    task automatic start_run(input logic [BW-1:0] b, input int md, input bit exp_load,
                             input bit push_done, input logic [2:0] st, input int lat,
                             input logic [6:0] fl, input logic [BW-1:0] eb, input int cy);
        exp_t e;
        @(negedge clk);
        chk("ready_before_start", BW'(ready_out), BW'(1));
        mode     = md;
        board_in = b;
        start_in = 1'b1;
        e.acc = ncyc; e.lat = lat; e.st = st; e.filled = fl; e.board = eb; e.cyc = cy;
        if (push_done) q.push_back(e);
        if (exp_load) ldq.push_back(ncyc);
        @(negedge clk);
        start_in = 1'b0;
        board_in = '0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            flag("done_timeout");
            q.delete();
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ready"}, BW'(ready_out), BW'(1));
        chk({tag, "_busy"}, BW'(busy_out), BW'(0));
        chk({tag, "_load"}, BW'(solver_load_out), BW'(0));
        chk({tag, "_done"}, BW'(done_out), BW'(0));
        chk({tag, "_status"}, BW'(status_out), BW'(0));
        chk({tag, "_filled"}, BW'(filled_out), BW'(0));
        chk({tag, "_board"}, board_out, '0);
        chk({tag, "_solver_board"}, solver_board_out, '0);
`ifdef SUDOKU_CYCLE_COUNT_EN
        chk({tag, "_cycles"}, BW'(cycles_out), BW'(0));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [BW-1:0] bad, p3, e3, p4, e4, p5;
        sol = make_solution();
        bad = set_cell(sol, 40, 4'hA);
        p3  = set_cell(set_cell(set_cell(set_cell(set_cell(set_cell(sol, 0, 4'd0), 1, 4'd0), 2, 4'd0), 3, 4'd0), 4, 4'd0), 5, 4'd0);
        e3  = set_cell(set_cell(set_cell(sol, 3, 4'd0), 4, 4'd0), 5, 4'd0);
        p4  = set_cell(set_cell(sol, 79, 4'd0), 80, 4'd0);
        e4  = set_cell(p4, 80, 4'd1);
        p5  = p4;

        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        // Full board: solved on the first RUN cycle.
        start_run(sol, 0, 1, 1, STATUS_SOLVED, 3, 7'd81, sol, 1);
        wait_drain(40);
        // Digit 0xA: rejected without loading the solver.
        start_run(bad, 0, 0, 1, STATUS_BAD_INPUT, 1, 7'd81, bad, 0);
        wait_drain(40);
        // Fills 75 -> 78 then holds: fixpoint declared on the 4th equal cycle.
        start_run(p3, 1, 1, 1, STATUS_STALLED, 10, 7'd78, e3, 8);
        wait_drain(40);
        // One cell toggles forever: timeout after 16 RUN cycles.
        start_run(p4, 2, 1, 1, STATUS_TIMEOUT, 18, 7'd80, e4, 16);
        wait_drain(40);
        // Board becomes full on the last budgeted cycle: solved wins over timeout.
        start_run(p5, 3, 1, 1, STATUS_SOLVED, 18, 7'd81, sol, 16);
        repeat (3) @(negedge clk);
        chk("ready_in_run", BW'(ready_out), BW'(0));
        start_in = 1'b1;
        board_in = bad;
        @(negedge clk);
        start_in = 1'b0;
        board_in = '0;
        wait_drain(40);

        // Reset mid-run: outputs clear immediately and no done follows.
        start_run(p4, 2, 1, 0, STATUS_NONE, 0, 7'd0, '0, 0);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_idle("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        start_run(sol, 0, 1, 1, STATUS_SOLVED, 3, 7'd81, sol, 1);
        wait_drain(40);
        repeat (3) @(negedge clk);
        chk("leftover_done", BW'(q.size()), BW'(0));
        chk("leftover_load", BW'(ldq.size()), BW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
